// File: rtl/demux_1_n_pack_pkg.sv
// rtl/demux_1_n_pack_pkg.sv - shared types and helpers for the 1:N packed-bus demux
package demux_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Widest lane count the all-ones template covers; slice it to N bits.
    localparam int MAX_N = 64;
    localparam logic [MAX_N-1:0] ALL_ONES = '1;

    // Bit position of the least significant bit of lane sel in the packed frame.
    function automatic int lane_lsb(input int sel, input int width);
        return sel * width;
    endfunction

endpackage

// File: rtl/demux_1_n_pack_if.sv
// rtl/demux_1_n_pack_if.sv - word-in / packed-frame-out handshake bundle
interface demux_1_n_pack_if #(
    parameter int N     = 4,
    parameter int WIDTH = 4
);
    localparam int SEL_W = $clog2(N);

    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic [WIDTH-1:0]   in_data;
    logic [N*WIDTH-1:0] frame_data;
    logic [N-1:0]       lane_valid;
    logic               frame_valid;
    logic               frame_ready;
    logic               sel_err;

    modport master (
        output in_valid, in_sel, in_data, frame_ready,
        input  in_ready, frame_data, lane_valid, frame_valid, sel_err
    );

    modport slave (
        input  in_valid, in_sel, in_data, frame_ready,
        output in_ready, frame_data, lane_valid, frame_valid, sel_err
    );
endinterface

// File: rtl/demux_1_n_pack_lane_reg.sv
// rtl/demux_1_n_pack_lane_reg.sv - one lane of the frame: data register plus written flag
module demux_lane_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Clear drops only the written flag; stale data stays visible after release.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr) begin
            valid_d = 1'b0;
        end
        if (we) begin
            data_d  = wdata;
            valid_d = 1'b1;
        end
    end

    // Lane storage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
endmodule

// File: rtl/demux_1_n_pack.sv
// rtl/demux_1_n_pack.sv - collects lane-addressed words into a packed frame with valid/ready release
module demux_1_n_pack
    import demux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_1_n_pack_if.slave       bus
);
    localparam int SEL_W = $clog2(N);
    // Select compared one bit wider so that e.g. sel=3 with N=3 cannot alias a valid lane.
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    state_t         state_q, state_d;
    logic           sel_err_q, sel_err_d;
    logic           accept;
    logic           in_range;
    logic [SEL_W:0] sel_ext;
    logic [N-1:0]   we_vec;
    logic [N-1:0]   lane_valid_w;
    logic [N-1:0]   lane_valid_next;
    logic           release_frame;

    assign bus.in_ready    = (state_q == FILL) && !rst;
    assign accept          = bus.in_valid && bus.in_ready;
    assign sel_ext         = {1'b0, bus.in_sel};
    assign in_range        = (sel_ext < N_EXT);
    assign release_frame   = (state_q == HOLD) && bus.frame_ready;

    // One-hot write enable for the addressed lane; out-of-range selects enable nothing.
    always_comb begin
        we_vec = '0;
        for (int k = 0; k < N; k++) begin
            if (accept && in_range && (sel_ext == (SEL_W+1)'(k))) begin
                we_vec[k] = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
                .clk   (clk),
                .rst   (rst),
                .we    (we_vec[g]),
                .clr   (release_frame),
                .wdata (bus.in_data),
                .data  (bus.frame_data[lane_lsb(g, WIDTH) +: WIDTH]),
                .valid (lane_valid_w[g])
            );
        end
    endgenerate

    assign lane_valid_next = lane_valid_w | we_vec;

    // Enter HOLD once this cycle's write completes the mask; leave only on consumer ready.
    always_comb begin
        state_d   = state_q;
        sel_err_d = accept && !in_range;
        case (state_q)
            FILL: begin
                if (lane_valid_next == ALL_ONES[N-1:0]) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.frame_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // FSM state and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.lane_valid  = lane_valid_w;
    assign bus.frame_valid = (state_q == HOLD);
    assign bus.sel_err     = sel_err_q;
endmodule

// File: tb/tb_demux_1_n_pack.sv
// tb/tb_demux_1_n_pack.sv - directed and model-checked bench for demux_1_n_pack
module tb_demux_1_n_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    demux_1_n_pack_if #(.N(4), .WIDTH(4)) b4 ();
    demux_1_n_pack_if #(.N(3), .WIDTH(8)) b3 ();

    demux_1_n_pack #(.N(4), .WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    demux_1_n_pack #(.N(3), .WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic w4(input logic [1:0] sel, input logic [3:0] data);
        b4.in_valid = 1'b1;
        b4.in_sel   = sel;
        b4.in_data  = data;
        step();
        b4.in_valid = 1'b0;
    endtask

    task automatic w3(input logic [1:0] sel, input logic [7:0] data);
        b3.in_valid = 1'b1;
        b3.in_sel   = sel;
        b3.in_data  = data;
        step();
        b3.in_valid = 1'b0;
    endtask

    task automatic rel4();
        b4.frame_ready = 1'b1;
        step();
        b4.frame_ready = 1'b0;
    endtask

    logic [15:0] m_frame;
    logic [3:0]  m_mask;
    logic        m_hold;
    logic        acc;
    int          words;
    int          cycles;
    int          acc_cnt;

    initial begin
        b4.in_valid = 0; b4.in_sel = 0; b4.in_data = 0; b4.frame_ready = 0;
        b3.in_valid = 0; b3.in_sel = 0; b3.in_data = 0; b3.frame_ready = 0;

        // 1. reset
        rst = 1'b1;
        step();
        step();
        chk("rst_frame_data", 64'(b4.frame_data), 64'h0000);
        chk("rst_lane_valid", 64'(b4.lane_valid), 64'h0);
        chk("rst_frame_valid", 64'(b4.frame_valid), 64'h0);
        chk("rst_in_ready", 64'(b4.in_ready), 64'h0);
        chk("rst_sel_err", 64'(b4.sel_err), 64'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(b4.in_ready), 64'h1);

        // 2. fill in order
        w4(2'd0, 4'hA);
        w4(2'd1, 4'hB);
        w4(2'd2, 4'hC);
        chk("fill3_frame_valid", 64'(b4.frame_valid), 64'h0);
        chk("fill3_lane_valid", 64'(b4.lane_valid), 64'h7);
        w4(2'd3, 4'hD);
        chk("fill4_frame_valid", 64'(b4.frame_valid), 64'h1);
        chk("fill4_frame_data", 64'(b4.frame_data), 64'hDCBA);
        chk("fill4_in_ready", 64'(b4.in_ready), 64'h0);
        rel4();
        chk("rel_lane_valid", 64'(b4.lane_valid), 64'h0);
        chk("rel_in_ready", 64'(b4.in_ready), 64'h1);
        chk("rel_frame_valid", 64'(b4.frame_valid), 64'h0);
        chk("rel_frame_kept", 64'(b4.frame_data), 64'hDCBA);

        // 3. overwrite plus out-of-order fill
        w4(2'd2, 4'h5);
        chk("ow1_frame_data", 64'(b4.frame_data), 64'hD5BA);
        chk("ow1_lane_valid", 64'(b4.lane_valid), 64'h4);
        w4(2'd2, 4'h7);
        chk("ow2_frame_data", 64'(b4.frame_data), 64'hD7BA);
        chk("ow2_lane_valid", 64'(b4.lane_valid), 64'h4);
        chk("ow2_sel_err", 64'(b4.sel_err), 64'h0);
        w4(2'd3, 4'hE);
        w4(2'd1, 4'h9);
        chk("ooo_frame_valid_early", 64'(b4.frame_valid), 64'h0);
        chk("ooo_frame_data_mid", 64'(b4.frame_data), 64'hE79A);
        w4(2'd0, 4'h3);
        chk("ooo_frame_valid", 64'(b4.frame_valid), 64'h1);
        chk("ooo_frame_data", 64'(b4.frame_data), 64'hE793);

        // 4. backpressure in HOLD
        acc_cnt = 0;
        b4.in_valid = 1'b1;
        b4.in_sel   = 2'd0;
        b4.in_data  = 4'hF;
        for (int i = 0; i < 10; i++) begin
            if (b4.in_valid && b4.in_ready) acc_cnt++;
            step();
        end
        b4.in_valid = 1'b0;
        chk("bp_accepts", 64'(acc_cnt), 64'd0);
        chk("bp_frame_data", 64'(b4.frame_data), 64'hE793);
        chk("bp_frame_valid", 64'(b4.frame_valid), 64'h1);
        chk("bp_lane_valid", 64'(b4.lane_valid), 64'hF);
        rel4();

        // 5. bad select on N=3, WIDTH=8
        w3(2'd3, 8'hAA);
        chk("bad_sel_err", 64'(b3.sel_err), 64'h1);
        chk("bad_lane_valid", 64'(b3.lane_valid), 64'h0);
        chk("bad_in_ready", 64'(b3.in_ready), 64'h1);
        chk("bad_frame_data", 64'(b3.frame_data), 64'h0);
        step();
        chk("bad_sel_err_once", 64'(b3.sel_err), 64'h0);
        w3(2'd0, 8'h11);
        w3(2'd1, 8'h22);
        chk("n3_frame_valid_early", 64'(b3.frame_valid), 64'h0);
        w3(2'd2, 8'h33);
        chk("n3_frame_valid", 64'(b3.frame_valid), 64'h1);
        chk("n3_frame_data", 64'(b3.frame_data), 64'h332211);
        b3.frame_ready = 1'b1;
        step();
        b3.frame_ready = 1'b0;
        chk("n3_rel_lane_valid", 64'(b3.lane_valid), 64'h0);

        // 6. reset mid-fill
        w4(2'd0, 4'h1);
        w4(2'd1, 4'h2);
        chk("mid_lane_valid", 64'(b4.lane_valid), 64'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_lane_valid", 64'(b4.lane_valid), 64'h0);
        chk("midrst_frame_data", 64'(b4.frame_data), 64'h0);
        w4(2'd0, 4'h4);
        w4(2'd1, 4'h5);
        w4(2'd2, 4'h6);
        chk("refill_not_done", 64'(b4.frame_valid), 64'h0);
        w4(2'd3, 4'h8);
        chk("refill_frame_valid", 64'(b4.frame_valid), 64'h1);
        chk("refill_frame_data", 64'(b4.frame_data), 64'h8654);
        rel4();

        // Random stream checked against a behavioural model
        m_frame = 16'h8654;
        m_mask  = 4'h0;
        m_hold  = 1'b0;
        words   = 0;
        cycles  = 0;
        while (words < 200 && cycles < 5000) begin
            b4.in_valid    = ($urandom_range(0, 3) != 0);
            b4.in_sel      = 2'($urandom_range(0, 3));
            b4.in_data     = 4'($urandom_range(0, 15));
            b4.frame_ready = ($urandom_range(0, 1) == 1);
            #1;
            chk("rnd_in_ready", 64'(b4.in_ready), 64'(!m_hold));
            acc = b4.in_valid && !m_hold;
            if (!m_hold) begin
                if (acc) begin
                    m_frame[b4.in_sel*4 +: 4] = b4.in_data;
                    m_mask[b4.in_sel] = 1'b1;
                    words++;
                end
                if (m_mask == 4'hF) m_hold = 1'b1;
            end else if (b4.frame_ready) begin
                m_hold = 1'b0;
                m_mask = 4'h0;
            end
            step();
            cycles++;
            chk("rnd_frame_data", 64'(b4.frame_data), 64'(m_frame));
            chk("rnd_lane_valid", 64'(b4.lane_valid), 64'(m_mask));
            chk("rnd_frame_valid", 64'(b4.frame_valid), 64'(m_hold));
            for (int k = 0; k < 4; k++) begin
                if (m_hold) chk("rnd_lane_slice", 64'(b4.frame_data[k*4 +: 4]), 64'(m_frame[k*4 +: 4]));
            end
        end
        b4.in_valid    = 1'b0;
        b4.frame_ready = 1'b0;
        chk("rnd_budget", 64'(words >= 200), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
